// File: rtl/data_path_if.sv
// Control and data bundle between the processor controller (master) and the datapath (slave).
interface data_path_if;
   logic [7:0]  D_Addr;
   logic        D_W_en;
   logic        RF_s;
   logic [3:0]  RF_W_Addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic [2:0]  ALU_s0;
   logic [15:0] ALU_inA;
   logic [15:0] ALU_inB;
   logic [15:0] ALU_out;

   modport master (
      output D_Addr, D_W_en, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
      input  ALU_inA, ALU_inB, ALU_out
   );

   modport slave (
      input  D_Addr, D_W_en, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
      output ALU_inA, ALU_inB, ALU_out
   );
endinterface

// File: rtl/data_path.sv
// 16-bit datapath: 256x16 data RAM, 16x16 register file, write-back mux and 8-function ALU.
// Optional macro RAM_INIT_EN preloads RAM word 0 = 20 and word 1 = 25 at power-up.
module data_path (
   input  logic       Clock,
   input  logic       Reset,
   data_path_if.slave bus
);

   logic [15:0] rf_q [16] = '{default: 16'd0};
`ifdef RAM_INIT_EN
   logic [15:0] mem_q [256] = '{0: 16'd20, 1: 16'd25, default: 16'd0};
`else
   logic [15:0] mem_q [256] = '{default: 16'd0};
`endif
   logic [7:0]  addr_q;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [15:0] rd_data;
   logic [15:0] alu_res;
   logic [15:0] wb_d;

   assign opa     = rf_q[bus.RF_Ra_Addr];
   assign opb     = rf_q[bus.RF_Rb_Addr];
   // Address is registered but read data is not, so a same-edge write is seen immediately.
   assign rd_data = mem_q[addr_q];

   assign bus.ALU_inA = opa;
   assign bus.ALU_inB = opb;
   assign bus.ALU_out = alu_res;

   // ALU function decode
   always_comb begin
      alu_res = 16'd0;
      case (bus.ALU_s0)
         3'd0:    alu_res = 16'd0;
         3'd1:    alu_res = opa + opb;
         3'd2:    alu_res = opa - opb;
         3'd3:    alu_res = opa;
         3'd4:    alu_res = opa ^ opb;
         3'd5:    alu_res = opa | opb;
         3'd6:    alu_res = opa & opb;
         3'd7:    alu_res = opa + 16'd1;
         default: alu_res = 16'd0;
      endcase
   end

   // Write-back mux
   always_comb begin
      wb_d = alu_res;
      if (bus.RF_s) begin
         wb_d = rd_data;
      end else begin
         wb_d = alu_res;
      end
   end

   // Register file and RAM address register, cleared asynchronously
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= 16'd0;
         end
         addr_q <= 8'd0;
      end else begin
         if (bus.RF_W_en) begin
            rf_q[bus.RF_W_Addr] <= wb_d;
         end
         addr_q <= bus.D_Addr;
      end
   end

   // RAM array: contents survive reset, but writes are blocked while it is asserted
   always_ff @(posedge Clock) begin
      if (!Reset && bus.D_W_en) begin
         mem_q[bus.D_Addr] <= opa;
      end
   end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed sequences, an ALU vector table and random traffic
// compared against an array-based reference model.
module tb_data_path;

   logic clk;
   logic rst;
   data_path_if bus();

   data_path u_dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_rf  [16];
   logic [15:0] m_ram [256];
   logic [7:0]  m_addr;
   logic [15:0] obs_out;

   typedef struct {
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  sel;
      logic [15:0] exp_out;
   } vec_t;

   function automatic logic [15:0] alu_ref(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
      int unsigned r;
      case (sel)
         3'd0:    r = 0;
         3'd1:    r = int'(a) + int'(b);
         3'd2:    r = int'(a) + 65536 - int'(b);
         3'd3:    r = a;
         3'd4:    r = a ^ b;
         3'd5:    r = a | b;
         3'd6:    r = a & b;
         default: r = int'(a) + 1;
      endcase
      return 16'(r % 65536);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
      m_addr = 8'd0;
   endtask

   // One controller cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input logic dw, input logic [7:0] da, input logic rfs, input logic rfw,
                       input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [2:0] sel);
      logic [15:0] a, b, q, wb;
      bus.D_W_en = dw;  bus.D_Addr = da;  bus.RF_s = rfs;  bus.RF_W_en = rfw;
      bus.RF_W_Addr = wa;  bus.RF_Ra_Addr = ra;  bus.RF_Rb_Addr = rb;  bus.ALU_s0 = sel;
      #3;
      a  = m_rf[ra];
      b  = m_rf[rb];
      q  = alu_ref(sel, a, b);
      wb = rfs ? m_ram[m_addr] : q;
      obs_out = bus.ALU_out;
      check("ALU_inA", bus.ALU_inA, a);
      check("ALU_inB", bus.ALU_inB, b);
      check("ALU_out", bus.ALU_out, q);
      @(posedge clk);
      #1;
      if (rfw) m_rf[wa] = wb;
      if (dw)  m_ram[da] = a;
      m_addr = da;
   endtask

   // Reset raised mid-cycle with the given pending writes, released just after the next edge.
   task automatic mid_reset(input logic dw, input logic [7:0] da, input logic rfw, input logic [3:0] wa,
                            input logic [3:0] ra);
      bus.D_W_en = dw;  bus.D_Addr = da;  bus.RF_s = 1'b0;  bus.RF_W_en = rfw;
      bus.RF_W_Addr = wa;  bus.RF_Ra_Addr = ra;  bus.RF_Rb_Addr = wa;  bus.ALU_s0 = 3'd7;
      #2;
      rst = 1'b1;
      #1;
      check("reset_inA", bus.ALU_inA, 16'd0);
      check("reset_inB", bus.ALU_inB, 16'd0);
      check("reset_out_sel7", bus.ALU_out, 16'd1);
      @(posedge clk);
      #1;
      check("reset_hold_inA", bus.ALU_inA, 16'd0);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t vecs [9];

   initial begin
      rst = 1'b0;
      bus.D_W_en = 1'b0;  bus.D_Addr = 8'd0;  bus.RF_s = 1'b0;  bus.RF_W_en = 1'b0;
      bus.RF_W_Addr = 4'd0;  bus.RF_Ra_Addr = 4'd0;  bus.RF_Rb_Addr = 4'd0;  bus.ALU_s0 = 3'd0;
      model_reset();
      for (int i = 0; i < 256; i++) m_ram[i] = 16'd0;
`ifdef RAM_INIT_EN
      m_ram[0] = 16'd20;
      m_ram[1] = 16'd25;
`endif
      vecs[0] = '{ra: 4'd0, rb: 4'd1, sel: 3'd0, exp_out: 16'd0};
      vecs[1] = '{ra: 4'd0, rb: 4'd1, sel: 3'd1, exp_out: 16'd45};
      vecs[2] = '{ra: 4'd0, rb: 4'd1, sel: 3'd2, exp_out: 16'd65531};
      vecs[3] = '{ra: 4'd0, rb: 4'd1, sel: 3'd3, exp_out: 16'd20};
      vecs[4] = '{ra: 4'd0, rb: 4'd1, sel: 3'd4, exp_out: 16'd13};
      vecs[5] = '{ra: 4'd0, rb: 4'd1, sel: 3'd5, exp_out: 16'd29};
      vecs[6] = '{ra: 4'd0, rb: 4'd1, sel: 3'd6, exp_out: 16'd16};
      vecs[7] = '{ra: 4'd0, rb: 4'd1, sel: 3'd7, exp_out: 16'd21};
      vecs[8] = '{ra: 4'd11, rb: 4'd1, sel: 3'd7, exp_out: 16'd0};

      @(posedge clk); @(posedge clk); #1;

      // Power-up reset
      mid_reset(1'b0, 8'd0, 1'b0, 4'd0, 4'd0);

      // RAM load: word 0 into R0 (port A), word 1 into R1 (port B)
      step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'd0);
      step(1'b0, 8'd0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'd0);
      step(1'b0, 8'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'd0);
      step(1'b0, 8'd1, 1'b1, 1'b1, 4'd1, 4'd0, 4'd1, 3'd0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 3'd0);
`ifdef RAM_INIT_EN
      check("ram_load_A", bus.ALU_inA, 16'd20);
      check("ram_load_B", bus.ALU_inB, 16'd25);
`endif

      // Build R0 = 20, R1 = 25, R11 = 0xFFFF through the ALU
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd5, 4'd10, 4'd10, 3'd7);  // R5 = 1
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd6, 4'd5,  4'd5,  3'd1);  // R6 = 2
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd6, 4'd6,  4'd6,  3'd1);  // R6 = 4
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd7, 4'd6,  4'd6,  3'd1);  // R7 = 8
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd7, 4'd7,  4'd7,  3'd1);  // R7 = 16
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd0, 4'd7,  4'd6,  3'd1);  // R0 = 20
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd1, 4'd0,  4'd6,  3'd1);  // R1 = 24
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd1, 4'd1,  4'd1,  3'd7);  // R1 = 25
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd11, 4'd10, 4'd5, 3'd2);  // R11 = 0 - 1

      // ALU sweep from the vector table
      foreach (vecs[i]) begin
         step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, vecs[i].ra, vecs[i].rb, vecs[i].sel);
         check($sformatf("alu_vec%0d", i), obs_out, vecs[i].exp_out);
      end

      // Write-back 45 into R2, store it to RAM word 2, round trip into R3
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd1, 3'd1);
      step(1'b1, 8'd2, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 3'd3);
      step(1'b0, 8'd2, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 3'd3);
      step(1'b0, 8'd2, 1'b1, 1'b1, 4'd3, 4'd2, 4'd0, 3'd0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd3, 3'd0);
      check("round_trip_B", bus.ALU_inB, 16'd45);

      // Simultaneous RF and RAM write in one cycle, then read the same word back
      step(1'b1, 8'd9, 1'b0, 1'b1, 4'd2, 4'd2, 4'd0, 3'd7);
      step(1'b0, 8'd9, 1'b1, 1'b1, 4'd4, 4'd2, 4'd4, 3'd0);
      step(1'b0, 8'd9, 1'b0, 1'b0, 4'd0, 4'd2, 4'd4, 3'd0);
      check("simul_rf", bus.ALU_inA, 16'd46);
      check("simul_ram", bus.ALU_inB, 16'd45);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 8'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
      end

      // Reset during pending writes: set R2 = 45, store to word 5, then reset over a write
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 3'd0);
      step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 3'd7);
      for (int i = 0; i < 44; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2, 4'd2, 4'd2, 3'd7);
      step(1'b1, 8'd5, 1'b0, 1'b1, 4'd9, 4'd2, 4'd2, 3'd7);
      mid_reset(1'b1, 8'd5, 1'b1, 4'd9, 4'd9);
      step(1'b0, 8'd5, 1'b0, 1'b0, 4'd0, 4'd9, 4'd0, 3'd0);
      check("reset_target_reg", obs_out, 16'd0);
      step(1'b0, 8'd5, 1'b1, 1'b1, 4'd4, 4'd9, 4'd0, 3'd0);
      step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 4'd9, 4'd4, 3'd0);
      check("reset_ram_kept", bus.ALU_inB, 16'd45);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_path.md
# data_path

16-bit processor datapath joining a 256×16 synchronous data RAM, a 16×16 register file, a 2:1 write-back mux and an 8-function combinational ALU. It sits beneath the processor controller, which drives every address, enable and select each cycle. Register file port A feeds both the ALU A operand and the RAM write data. The write-back mux returns either the ALU result or the RAM read data to the register file.

## Interface
- No parameters: widths are fixed at 16-bit data, 8-bit RAM address and 4-bit register address.
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- D_Addr  input  8  RAM address.
- D_W_en  input  1  RAM write enable.
- RF_s  input  1  write-back mux select: 1 = RAM read data, 0 = ALU result.
- RF_W_Addr  input  4  register file write address.
- RF_W_en  input  1  register file write enable.
- RF_Ra_Addr  input  4  register file read port A address.
- RF_Rb_Addr  input  4  register file read port B address.
- ALU_s0  input  3  ALU function select.
- ALU_inA  output  16  register file port A data, which is also the ALU A operand.
- ALU_inB  output  16  register file port B data, which is also the ALU B operand.
- ALU_out  output  16  ALU result.

## Operation
- **RAM**
  - 256 words × 16 bits.
  - Address is registered on the rising edge of Clock.
  - Read data is the word at the registered address; there is no output register.
  - When D_W_en is high at the edge, the RAM writes ALU_inA to D_Addr.
  - Read-during-write to the same address returns the newly written data.
- **Register file**
  - 16 × 16-bit registers; all registers, including R0, are writable.
  - When RF_W_en is high at the edge, the mux output is written to RF_W_Addr.
  - Both read ports are combinational.
  - A read of the register being written shows the old value until the edge.
- **Write-back mux**: combinational; output = RF_s ? RAM read data : ALU result.
- **ALU** (combinational; all results truncated to 16 bits, with no carry or flag outputs):
  - 0: Q = 0
  - 1: Q = A + B
  - 2: Q = A − B, two's-complement wrap.
  - 3: Q = A
  - 4: Q = A ^ B
  - 5: Q = A | B
  - 6: Q = A & B
  - 7: Q = A + 1, so 16'hFFFF wraps to 0.
- **Reset** (asynchronous assert, released synchronously by the user):
  - All 16 registers clear to 0.
  - The RAM address register clears to 0.
  - Writes to both RAM and register file are suppressed while Reset is high.
  - RAM contents are not cleared.
- **Output values during and after reset**
  - ALU_inA = 0 and ALU_inB = 0.
  - ALU_out = f(0,0) for the current ALU_s0; for example, 1 when ALU_s0 = 7.
- **Reset mid-operation**: any write pending at the next edge is discarded.

## Timing
- **RAM read latency**: data for a D_Addr applied before edge N is valid after edge N.
  - RF_s = 1 with RF_W_en high at edge N+1 captures that data into the register file.
- **Register file**: a write at edge N is visible on ALU_inA/ALU_inB immediately after edge N.
- **ALU_out**: combinational from the register addresses and ALU_s0; zero cycles of latency.
- **RAM write**: takes ALU_inA as sampled at edge N; the word is readable after edge N.
- **Simultaneous RAM and register file writes in one cycle**:
  - Both are allowed.
  - The register file takes the pre-edge mux value.
  - The RAM takes the pre-edge ALU_inA.

## Configuration
- RAM_INIT_EN
  - Defined: RAM powers up with address 0 = 16'd20, address 1 = 16'd25 and all other words = 0.
  - Undefined: all RAM words power up as 0.
  - In both cases the register file powers up as 0.

## Test plan
- **Power-up and reset**: assert Reset mid-cycle.
  - Required: ALU_inA = ALU_inB = 0 with no wait for a clock edge.
  - Required: with ALU_s0 = 7, ALU_out = 1.
- **RAM load** (RAM_INIT_EN defined):
  - Stimulus: D_Addr = 0, one cycle, then RF_s = 1, RF_W_en = 1, RF_W_Addr = 0, then RF_Ra_Addr = 0.
  - Required: ALU_inA = 20.
  - Repeat with D_Addr = 1 into R1 read on port B. Required: ALU_inB = 25.
- **ALU sweep** (A = 20, B = 25):
  - Sel 0..7 → 0, 45, 65531, 20, 13, 29, 16, 21.
  - Also A = 16'hFFFF with Sel 7 → 0.
- **Write-back and store**:
  - Stimulus: RF_s = 0, write ALU_out = 45 into R2, then RF_Ra_Addr = 2 with D_Addr = 2 and D_W_en = 1 for one cycle.
  - Required: RAM word 2 = 45.
- **Round trip**: read RAM address 2 with RF_s = 1 into R3, then RF_Rb_Addr = 3 → ALU_inB = 45.
- **Reset during write**: raise Reset with RF_W_en = 1 and D_W_en = 1 before the edge.
  - Required: the target register reads 0.
  - Required: the RAM word is unchanged.
